// File: rtl/pmul_word_sequencer_if.sv
// Signal bundle between the point-mult word sequencer, its register block and the core.
// slave is the sequencer's view; master is the register-block/core side.
interface pmul_word_sequencer_if #(
  parameter int pWORDS  = 8,
  parameter int pWORD_W = 32,
  parameter int pADDR_W = 3
);
  localparam int OP_W = pWORDS * pWORD_W;

  logic                start_i;
  logic [pWORD_W-1:0]  k_word_i;
  logic [pWORD_W-1:0]  gx_word_i;
  logic [pWORD_W-1:0]  gy_word_i;
  logic [pADDR_W-1:0]  k_addr_o;
  logic [pADDR_W-1:0]  gx_addr_o;
  logic [pADDR_W-1:0]  gy_addr_o;
  logic [pWORD_W-1:0]  rx_word_o;
  logic [pWORD_W-1:0]  ry_word_o;
  logic [pADDR_W-1:0]  rx_addr_o;
  logic [pADDR_W-1:0]  ry_addr_o;
  logic                rx_wren_o;
  logic                ry_wren_o;
  logic [OP_W-1:0]     core_k_o;
  logic [OP_W-1:0]     core_gx_o;
  logic [OP_W-1:0]     core_gy_o;
  logic                core_start_o;
  logic                core_done_i;
  logic [OP_W-1:0]     core_rx_i;
  logic [OP_W-1:0]     core_ry_i;
  logic                ready_o;
  logic                busy_o;
  logic                done_o;

  modport slave (
    input  start_i, k_word_i, gx_word_i, gy_word_i, core_done_i, core_rx_i, core_ry_i,
    output k_addr_o, gx_addr_o, gy_addr_o, rx_word_o, ry_word_o, rx_addr_o, ry_addr_o,
           rx_wren_o, ry_wren_o, core_k_o, core_gx_o, core_gy_o, core_start_o,
           ready_o, busy_o, done_o
  );

  modport master (
    output start_i, k_word_i, gx_word_i, gy_word_i, core_done_i, core_rx_i, core_ry_i,
    input  k_addr_o, gx_addr_o, gy_addr_o, rx_word_o, ry_word_o, rx_addr_o, ry_addr_o,
           rx_wren_o, ry_wren_o, core_k_o, core_gx_o, core_gy_o, core_start_o,
           ready_o, busy_o, done_o
  );
endinterface

// File: rtl/pmul_word_sequencer.sv
// Fetches k/Gx/Gy word-serially, launches the P-256 core, writes Rx/Ry back; 19 cycles + core latency,
// no backpressure (start_i ignored unless ready_o). PMUL_SEQ_ZEROIZE_EN clears operands/results after use.
module pmul_word_sequencer #(
  parameter int pWORDS  = 8,
  parameter int pWORD_W = 32,
  parameter int pADDR_W = 3
) (
  input logic                  crypto_clk,
  input logic                  reset_n,
  pmul_word_sequencer_if.slave bus
);
  localparam int OP_W = pWORDS * pWORD_W;
  localparam logic [3:0] LD_LAST = 4'(pWORDS);
  localparam logic [3:0] ST_LAST = 4'(pWORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_STORE, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic [OP_W-1:0]     r_k, r_gx, r_gy, r_rx, r_ry;
  logic                w_cap_k, w_cap_g, w_cap_res, w_clr;
  logic [pADDR_W-1:0]  w_ld_addr, w_k_idx, w_g_idx, w_st_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap_k     = 1'b0;
    w_cap_g     = 1'b0;
    w_cap_res   = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_LOAD: begin
        // registered Gx/Gy source lags the address by one cycle
        w_cap_k = (r_cnt < LD_LAST);
        w_cap_g = (r_cnt != 4'd0);
        if (r_cnt == LD_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_RUN: begin
        // cnt==0 marks the launch cycle, where a stale done must not complete
        if (r_cnt == 4'd0) begin
          w_cnt_nxt = 4'd1;
        end else if (bus.core_done_i) begin
          w_cap_res   = 1'b1;
          w_state_nxt = S_STORE;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_STORE: begin
        if (r_cnt == ST_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = 4'd0;
`ifdef PMUL_SEQ_ZEROIZE_EN
          w_clr = 1'b1;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_ld_addr = (r_cnt >= LD_LAST) ? pADDR_W'(pWORDS - 1) : r_cnt[pADDR_W-1:0];
  assign w_k_idx   = r_cnt[pADDR_W-1:0];
  assign w_g_idx   = r_cnt[pADDR_W-1:0] - pADDR_W'(1);
  assign w_st_idx  = r_cnt[pADDR_W-1:0];

  always_ff @(posedge crypto_clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_k     <= '0;
      r_gx    <= '0;
      r_gy    <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cap_k) r_k[w_k_idx*pWORD_W +: pWORD_W] <= bus.k_word_i;
      if (w_cap_g) begin
        r_gx[w_g_idx*pWORD_W +: pWORD_W] <= bus.gx_word_i;
        r_gy[w_g_idx*pWORD_W +: pWORD_W] <= bus.gy_word_i;
      end
      if (w_cap_res) begin
        r_rx <= bus.core_rx_i;
        r_ry <= bus.core_ry_i;
      end
      if (w_clr) begin
        r_k  <= '0;
        r_gx <= '0;
        r_gy <= '0;
        r_rx <= '0;
        r_ry <= '0;
      end
    end
  end

  assign bus.k_addr_o     = (r_state == S_LOAD) ? w_ld_addr : '0;
  assign bus.gx_addr_o    = (r_state == S_LOAD) ? w_ld_addr : '0;
  assign bus.gy_addr_o    = (r_state == S_LOAD) ? w_ld_addr : '0;
  assign bus.rx_wren_o    = (r_state == S_STORE);
  assign bus.ry_wren_o    = (r_state == S_STORE);
  assign bus.rx_addr_o    = (r_state == S_STORE) ? w_st_idx : '0;
  assign bus.ry_addr_o    = (r_state == S_STORE) ? w_st_idx : '0;
  assign bus.rx_word_o    = (r_state == S_STORE) ? r_rx[w_st_idx*pWORD_W +: pWORD_W] : '0;
  assign bus.ry_word_o    = (r_state == S_STORE) ? r_ry[w_st_idx*pWORD_W +: pWORD_W] : '0;
  assign bus.core_start_o = (r_state == S_RUN) && (r_cnt == 4'd0);
  assign bus.ready_o      = (r_state == S_IDLE);
  assign bus.busy_o       = (r_state != S_IDLE);
  assign bus.done_o       = (r_state == S_DONE);

`ifdef PMUL_SEQ_ZEROIZE_EN
  assign bus.core_k_o  = (r_state == S_RUN) ? r_k  : '0;
  assign bus.core_gx_o = (r_state == S_RUN) ? r_gx : '0;
  assign bus.core_gy_o = (r_state == S_RUN) ? r_gy : '0;
`else
  assign bus.core_k_o  = r_k;
  assign bus.core_gx_o = r_gx;
  assign bus.core_gy_o = r_gy;
`endif
endmodule
